// File: rtl/cache_sim_assoc.sv
// N-way set-associative cache timing/statistics model: tags, valid bits and LRU ages only.
// Optional write-back counter output wb_count is enabled by defining CACHE_WB_CNT_EN.
module cache_sim_assoc #(
    parameter int ADDR_W   = 15,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 10,
    parameter int WAYS     = 2,
    parameter int CNT_W    = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] adr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
`ifdef CACHE_WB_CNT_EN
    output logic [CNT_W-1:0]  wb_count,
`endif
    output logic [CNT_W-1:0]  access_count
);

    localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_WB     = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [TAG_W-1:0]   tag_req_q, tag_req_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [WAY_W-1:0]   way_q, way_d;
    logic [TAG_W-1:0]   vtag_q, vtag_d;
    logic               hit_q, hit_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;

    logic [TAG_W-1:0]   tag_mem_q [SETS][WAYS];
    logic [WAYS-1:0]    valid_q [SETS];

    logic [TAG_W-1:0]   set_tags [WAYS];
    logic [AGE_W-1:0]   set_age [WAYS];
    logic [WAYS-1:0]    set_valid;

    logic               hit_any, inv_any;
    logic [WAY_W-1:0]   hit_way, inv_way, lru_way, victim_way;

    logic               fill_we, age_we;
    logic [WAYS-1:0]    valid_row_d;
    logic [AGE_W-1:0]   age_row_d [WAYS];

    // Offset bits select a word within a line and play no part in the tag lookup.
    logic unused_offset;
    assign unused_offset = ^adr[OFFSET_W-1:0];

    assign set_valid = valid_q[idx_q];

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            set_tags[w] = tag_mem_q[idx_q][w];
        end
    end

    generate
        if (WAYS > 1) begin : g_lru
            logic [AGE_W-1:0] age_q [SETS][WAYS];

            // Ages start as the identity permutation so the LRU order is total from reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) begin
                        for (int w = 0; w < WAYS; w++) begin
                            age_q[s][w] <= AGE_W'(w);
                        end
                    end
                end else if (age_we) begin
                    for (int w = 0; w < WAYS; w++) begin
                        age_q[idx_q][w] <= age_row_d[w];
                    end
                end
            end

            always_comb begin
                for (int w = 0; w < WAYS; w++) begin
                    set_age[w] = age_q[idx_q][w];
                end
            end
        end else begin : g_no_lru
            always_comb begin
                set_age[0] = '0;
            end
        end
    endgenerate

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (set_valid[w] && (set_tags[w] == tag_req_q)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan leaves the lowest-numbered invalid way selected.
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (set_age[w] == AGE_W'(WAYS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
        victim_way = inv_any ? inv_way : lru_way;
    end

    always_comb begin
        valid_row_d = set_valid;
        valid_row_d[way_q] = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == way_q) begin
                age_row_d[w] = '0;
            end else if (set_age[w] < set_age[way_q]) begin
                age_row_d[w] = set_age[w] + AGE_W'(1);
            end else begin
                age_row_d[w] = set_age[w];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tag_req_d = tag_req_q;
        idx_d     = idx_q;
        way_d     = way_q;
        vtag_d    = vtag_q;
        hit_d     = hit_q;
        fill_we   = 1'b0;
        age_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tag_req_d = adr[ADDR_W-1 -: TAG_W];
                    idx_d     = adr[OFFSET_W +: INDEX_W];
                    state_d   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    way_d   = hit_way;
                    hit_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    way_d   = victim_way;
                    vtag_d  = set_tags[victim_way];
                    hit_d   = 1'b0;
                    state_d = set_valid[victim_way] ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    fill_we = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                age_we  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        acc_cnt_d = acc_cnt_q;
        if (state_q == S_RESP) begin
            if (acc_cnt_q != '1) begin
                acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end
            if (hit_q && (hit_cnt_q != '1)) begin
                hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef CACHE_WB_CNT_EN
    logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

    always_comb begin
        wb_cnt_d = wb_cnt_q;
        if ((state_q == S_WB) && mem_ack && (wb_cnt_q != '1)) begin
            wb_cnt_d = wb_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cnt_q <= '0;
        end else begin
            wb_cnt_q <= wb_cnt_d;
        end
    end

    assign wb_count = wb_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tag_req_q <= '0;
            idx_q     <= '0;
            way_q     <= '0;
            vtag_q    <= '0;
            hit_q     <= 1'b0;
            hit_cnt_q <= '0;
            acc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tag_req_q <= tag_req_d;
            idx_q     <= idx_d;
            way_q     <= way_d;
            vtag_q    <= vtag_d;
            hit_q     <= hit_d;
            hit_cnt_q <= hit_cnt_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    // Tags need no reset: a way is only consulted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem_q[idx_q][way_q] <= tag_req_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (fill_we) begin
            valid_q[idx_q] <= valid_row_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign resp_valid   = (state_q == S_RESP);
    assign resp_hit     = (state_q == S_RESP) && hit_q;
    assign mem_req      = (state_q == S_WB) || (state_q == S_FILL);
    assign mem_we       = (state_q == S_WB);
    assign hit_count    = hit_cnt_q;
    assign access_count = acc_cnt_q;

    always_comb begin
        mem_adr = '0;
        if (state_q == S_WB) begin
            mem_adr = {vtag_q, idx_q, {OFFSET_W{1'b0}}};
        end else if (state_q == S_FILL) begin
            mem_adr = {tag_req_q, idx_q, {OFFSET_W{1'b0}}};
        end
    end

endmodule

// File: tb/tb_cache_sim_assoc.sv
// Directed bench for cache_sim_assoc: default build, a 3-bit counter build and a direct-mapped build.
module tb_cache_sim_assoc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    logic        rst [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic [14:0] adr [3];
    logic        resp_valid [3];
    logic        resp_hit [3];
    logic        mem_req [3];
    logic        mem_we [3];
    logic [14:0] mem_adr [3];
    logic        mem_ack [3];

    logic [12:0] hc0, ac0, hc2, ac2;
    logic [2:0]  hc1, ac1;
`ifdef CACHE_WB_CNT_EN
    logic [12:0] wbc0, wbc2;
    logic [2:0]  wbc1;
`endif

    cache_sim_assoc dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .adr(adr[0]), .resp_valid(resp_valid[0]), .resp_hit(resp_hit[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_adr(mem_adr[0]), .mem_ack(mem_ack[0]),
        .hit_count(hc0),
`ifdef CACHE_WB_CNT_EN
        .wb_count(wbc0),
`endif
        .access_count(ac0)
    );

    cache_sim_assoc #(.CNT_W(3)) dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .adr(adr[1]), .resp_valid(resp_valid[1]), .resp_hit(resp_hit[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_adr(mem_adr[1]), .mem_ack(mem_ack[1]),
        .hit_count(hc1),
`ifdef CACHE_WB_CNT_EN
        .wb_count(wbc1),
`endif
        .access_count(ac1)
    );

    cache_sim_assoc #(.WAYS(1)) dut2 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .adr(adr[2]), .resp_valid(resp_valid[2]), .resp_hit(resp_hit[2]),
        .mem_req(mem_req[2]), .mem_we(mem_we[2]), .mem_adr(mem_adr[2]), .mem_ack(mem_ack[2]),
        .hit_count(hc2),
`ifdef CACHE_WB_CNT_EN
        .wb_count(wbc2),
`endif
        .access_count(ac2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One access on instance d; the memory acks each transaction after wait_cyc idle cycles.
    // lat counts cycles after the accept edge until resp_valid is seen.
    task automatic access(input int d, input logic [14:0] a, input int wait_cyc,
                          output logic hit, output int lat, output int n_wb,
                          output logic [14:0] wb_a, output logic [14:0] fill_a);
        int  waited;
        bit  done;
        hit = 1'b0; lat = -1; n_wb = 0; wb_a = '0; fill_a = '0; waited = 0; done = 1'b0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        adr[d] = a;
        @(negedge clk);
        req_valid[d] = 1'b0;
        adr[d] = 15'($urandom_range(0, 32767));
        for (int k = 1; k <= 60 && !done; k++) begin
            mem_ack[d] = 1'b0;
            if (resp_valid[d]) begin
                hit  = resp_hit[d];
                lat  = k;
                done = 1'b1;
            end else if (mem_req[d]) begin
                if (waited >= wait_cyc) begin
                    mem_ack[d] = 1'b1;
                    waited = 0;
                    if (mem_we[d]) begin
                        n_wb++;
                        wb_a = mem_adr[d];
                    end else begin
                        fill_a = mem_adr[d];
                    end
                end else begin
                    waited++;
                end
            end
            if (!done) @(negedge clk);
        end
        mem_ack[d] = 1'b0;
        if (!done) check_eq("resp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        hit;
        int          lat, n_wb, stab_bad;
        logic [14:0] wb_a, fill_a;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; adr[i] = '0; mem_ack[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_ready", req_ready[0], 1);
        check_eq("rst_resp_valid", resp_valid[0], 0);
        check_eq("rst_mem_req", mem_req[0], 0);
        check_eq("rst_mem_adr", mem_adr[0], 0);
        check_eq("rst_counts", {hc0, ac0}, 0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Cold miss, then a hit on the same line.
        access(0, 15'h0014, 0, hit, lat, n_wb, wb_a, fill_a);
        check_eq("cold_hit", hit, 0);
        check_eq("cold_wb", n_wb, 0);
        check_eq("cold_fill_adr", fill_a, 15'h0014);
        check_eq("cold_lat", lat, 3);
        @(negedge clk);
        check_eq("cold_acc", ac0, 1);
        check_eq("cold_hits", hc0, 0);
        access(0, 15'h0014, 0, hit, lat, n_wb, wb_a, fill_a);
        check_eq("rep_hit", hit, 1);
        check_eq("rep_lat", lat, 2);
        @(negedge clk);
        check_eq("rep_hits", hc0, 1);

        // Fill second way of set 5, touch way 0, then evict the LRU way.
        access(0, 15'h1014, 0, hit, lat, n_wb, wb_a, fill_a);
        check_eq("w1_hit", hit, 0);
        check_eq("w1_wb", n_wb, 0);
        check_eq("w1_fill_adr", fill_a, 15'h1014);
        access(0, 15'h0014, 0, hit, lat, n_wb, wb_a, fill_a);
        check_eq("w0_rehit", hit, 1);
        access(0, 15'h2014, 0, hit, lat, n_wb, wb_a, fill_a);
        check_eq("evict_hit", hit, 0);
        check_eq("evict_wb", n_wb, 1);
        check_eq("evict_wb_adr", wb_a, 15'h1014);
        check_eq("evict_fill_adr", fill_a, 15'h2014);
        check_eq("evict_lat", lat, 4);
        access(0, 15'h0014, 0, hit, lat, n_wb, wb_a, fill_a);
        check_eq("keep_mru_hit", hit, 1);
        access(0, 15'h1014, 0, hit, lat, n_wb, wb_a, fill_a);
        check_eq("evicted_miss", hit, 0);
        check_eq("evicted_wb_adr", wb_a, 15'h2014);
        @(negedge clk);
        check_eq("seq_acc", ac0, 7);
        check_eq("seq_hits", hc0, 3);
`ifdef CACHE_WB_CNT_EN
        check_eq("seq_wb_count", wbc0, 2);
`endif

        // Miss with the memory stalled for 10 cycles and a stray request in the middle.
        @(negedge clk);
        req_valid[0] = 1'b1;
        adr[0] = 15'h0020;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        stab_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(mem_req[0] && !mem_we[0] && mem_adr[0] == 15'h0020 &&
                  !req_ready[0] && !resp_valid[0])) stab_bad++;
            req_valid[0] = (i == 3);
            adr[0] = 15'h0030;
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        check_eq("stall_stable", stab_bad, 0);
        mem_ack[0] = 1'b1;
        @(negedge clk);
        mem_ack[0] = 1'b0;
        check_eq("stall_resp_valid", resp_valid[0], 1);
        check_eq("stall_resp_hit", resp_hit[0], 0);
        @(negedge clk);
        check_eq("stall_acc", ac0, 8);
        access(0, 15'h0030, 0, hit, lat, n_wb, wb_a, fill_a);
        check_eq("stray_not_queued", hit, 0);

        // Reset while FILL is waiting for memory.
        @(negedge clk);
        req_valid[0] = 1'b1;
        adr[0] = 15'h0040;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_mem_req", mem_req[0], 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check_eq("rst_mid_mem_req", mem_req[0], 0);
        check_eq("rst_mid_ready", req_ready[0], 1);
        check_eq("rst_mid_counts", {hc0, ac0}, 0);
        mem_ack[0] = 1'b1;
        @(negedge clk);
        mem_ack[0] = 1'b0;
        check_eq("late_ack_resp", resp_valid[0], 0);
        check_eq("late_ack_mem_req", mem_req[0], 0);
        access(0, 15'h0014, 0, hit, lat, n_wb, wb_a, fill_a);
        check_eq("post_rst_hit", hit, 0);
        check_eq("post_rst_wb", n_wb, 0);
        @(negedge clk);
        check_eq("post_rst_acc", ac0, 1);

        // 3-bit counters saturate.
        for (int i = 0; i < 10; i++) begin
            access(1, 15'h0014, 0, hit, lat, n_wb, wb_a, fill_a);
        end
        @(negedge clk);
        check_eq("sat_hits", hc1, 7);
        check_eq("sat_acc", ac1, 7);

        // Direct-mapped: two conflicting lines thrash one set.
        for (int i = 0; i < 4; i++) begin
            logic [14:0] a;
            a = (i % 2) ? 15'h1014 : 15'h0014;
            access(2, a, $urandom_range(0, 2), hit, lat, n_wb, wb_a, fill_a);
            check_eq("dm_hit", hit, 0);
            check_eq("dm_wb", n_wb, (i > 0) ? 1 : 0);
            if (i > 0) check_eq("dm_wb_adr", wb_a, (i % 2) ? 15'h0014 : 15'h1014);
        end
        @(negedge clk);
        check_eq("dm_acc", ac2, 4);
        check_eq("dm_hits", hc2, 0);
`ifdef CACHE_WB_CNT_EN
        check_eq("dm_wb_count", wbc2, 3);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
